// File: rtl/pyramid_sequencer.sv
// pyramid_sequencer: issues the BUILD/SOLVE/UPSAMPLE/WARP/ACCUM op stream for pyramidal Lucas-Kanade.
// Optional WAIT-state watchdog is compiled in when PYR_SEQ_WATCHDOG_EN is defined.
module pyramid_sequencer #(
    parameter int NUM_LEVELS      = 3,
    parameter int ITERS_PER_LEVEL = 1,
    parameter int TIMEOUT_CYCLES  = 2**20,
    parameter int LVL_W           = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic             op_start,
    output logic [2:0]       op_code,
    output logic [LVL_W-1:0] op_level,
    input  logic             op_done,
    output logic [1:0]       iter_idx,
    output logic [2:0]       current_state
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERROR = 3'd4
    } state_t;

    localparam logic [2:0]       OP_BUILD    = 3'd0;
    localparam logic [2:0]       OP_SOLVE    = 3'd1;
    localparam logic [2:0]       OP_UPSAMPLE = 3'd2;
    localparam logic [2:0]       OP_WARP     = 3'd3;
    localparam logic [2:0]       OP_ACCUM    = 3'd4;
    localparam logic [1:0]       LAST_ITER   = 2'(ITERS_PER_LEVEL - 1);
    localparam logic [LVL_W-1:0] LAST_LVL    = LVL_W'(NUM_LEVELS - 1);

    state_t             state_r;
    state_t             next_state_s;
    logic [2:0]         op_code_r;
    logic [LVL_W-1:0]   op_level_r;
    logic [1:0]         iter_r;
    logic [2:0]         next_code_s;
    logic [LVL_W-1:0]   next_level_s;
    logic [1:0]         next_iter_s;
    logic               end_of_iter_s;
    logic               last_op_s;
    logic               timeout_s;
    logic               busy_s;
    logic               done_s;
    logic               error_s;
    logic               op_start_s;
    logic               busy_r;
    logic               done_r;
    logic               error_r;
    logic               op_start_r;

`ifdef PYR_SEQ_WATCHDOG_EN
    localparam logic [20:0] WD_LAST = 21'(TIMEOUT_CYCLES - 1);
    logic [20:0] wd_cnt_r;

    // WAIT-cycle counter, cleared while the op is being launched
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt_r <= 21'd0;
        end else if (state_r == ST_ISSUE) begin
            wd_cnt_r <= 21'd0;
        end else if (state_r == ST_WAIT) begin
            wd_cnt_r <= wd_cnt_r + 21'd1;
        end else begin
            wd_cnt_r <= wd_cnt_r;
        end
    end

    assign timeout_s = (state_r == ST_WAIT) && (wd_cnt_r == WD_LAST);
`else
    logic unused_timeout_s;
    assign unused_timeout_s = ^21'(TIMEOUT_CYCLES);
    assign timeout_s        = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Successor op; the level-0 prefix SOLVE closes iteration 0 just like an ACCUM does
    always_comb begin
        next_code_s   = op_code_r;
        next_level_s  = op_level_r;
        next_iter_s   = iter_r;
        last_op_s     = 1'b0;
        end_of_iter_s = (op_code_r == OP_ACCUM) ||
                        ((op_code_r == OP_SOLVE) && (op_level_r == '0) && (iter_r == 2'd0));
        if (end_of_iter_s) begin
            if (iter_r != LAST_ITER) begin
                next_code_s = OP_WARP;
                next_iter_s = iter_r + 2'd1;
            end else if (op_level_r != LAST_LVL) begin
                next_code_s  = OP_UPSAMPLE;
                next_level_s = op_level_r + 1'b1;
                next_iter_s  = 2'd0;
            end else begin
                last_op_s = 1'b1;
            end
        end else begin
            case (op_code_r)
                OP_BUILD:    next_code_s = OP_SOLVE;
                OP_UPSAMPLE: next_code_s = OP_WARP;
                OP_WARP:     next_code_s = OP_SOLVE;
                OP_SOLVE:    next_code_s = OP_ACCUM;
                default:     last_op_s   = 1'b1;
            endcase
        end
    end

    // Next-state logic; abort outranks op_done, op_done outranks the watchdog
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) next_state_s = ST_ISSUE;
                else       next_state_s = ST_IDLE;
            end
            ST_ISSUE: begin
                if (abort) next_state_s = ST_IDLE;
                else       next_state_s = ST_WAIT;
            end
            ST_WAIT: begin
                if (abort)          next_state_s = ST_IDLE;
                else if (op_done)   next_state_s = last_op_s ? ST_DONE : ST_ISSUE;
                else if (timeout_s) next_state_s = ST_ERROR;
                else                next_state_s = ST_WAIT;
            end
            ST_DONE: next_state_s = ST_IDLE;
            ST_ERROR: begin
                if (abort)      next_state_s = ST_IDLE;
                else if (start) next_state_s = ST_ISSUE;
                else            next_state_s = ST_ERROR;
            end
            default: next_state_s = ST_IDLE;
        endcase
    end

    // Op descriptor, loaded only on entry to ISSUE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_code_r  <= 3'd0;
            op_level_r <= '0;
            iter_r     <= 2'd0;
        end else if (next_state_s == ST_ISSUE) begin
            if (state_r == ST_WAIT) begin
                op_code_r  <= next_code_s;
                op_level_r <= next_level_s;
                iter_r     <= next_iter_s;
            end else begin
                op_code_r  <= OP_BUILD;
                op_level_r <= '0;
                iter_r     <= 2'd0;
            end
        end else begin
            op_code_r  <= op_code_r;
            op_level_r <= op_level_r;
            iter_r     <= iter_r;
        end
    end

    // Output decode from the upcoming state so the flops track the state register
    always_comb begin
        busy_s     = (next_state_s == ST_ISSUE) || (next_state_s == ST_WAIT);
        done_s     = (next_state_s == ST_DONE);
        op_start_s = (next_state_s == ST_ISSUE);
`ifdef PYR_SEQ_WATCHDOG_EN
        error_s    = (next_state_s == ST_ERROR);
`else
        error_s    = 1'b0;
`endif
    end

    // Output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            error_r    <= 1'b0;
            op_start_r <= 1'b0;
        end else begin
            busy_r     <= busy_s;
            done_r     <= done_s;
            error_r    <= error_s;
            op_start_r <= op_start_s;
        end
    end

    assign busy          = busy_r;
    assign done          = done_r;
    assign error         = error_r;
    assign op_start      = op_start_r;
    assign op_code       = op_code_r;
    assign op_level      = op_level_r;
    assign iter_idx      = iter_r;
    assign current_state = state_r;

endmodule

// File: tb/tb_pyramid_sequencer.sv
// tb_pyramid_sequencer: scoreboard bench with a list-based reference of the op stream.
// Watchdog scenarios run only when PYR_SEQ_WATCHDOG_EN is defined.
`timescale 1ns/1ps
module tb_pyramid_sequencer;

    localparam int NL        = 4;
    localparam int IT        = 4;
    localparam int TO        = 16;
    localparam int LW        = 2;
    localparam int TOTAL     = 2 + 3 * (IT - 1) + (NL - 1) * (1 + 3 * IT);
    localparam int ABORT_IDX = 2 + 3 * (IT - 1) + 2;   // SOLVE at level 1

    typedef struct packed {
        logic [2:0] code;
        logic [1:0] lvl;
        logic [1:0] iter;
    } op_t;

    logic          clk = 1'b0;
    logic          rst_n, start, abort, op_done;
    logic          busy, done, error, op_start;
    logic [2:0]    op_code, current_state;
    logic [LW-1:0] op_level;
    logic [1:0]    iter_idx;

    op_t exp_q[$];
    op_t exp_op;
    op_t last_op;
    int  n_tests = 0;
    int  n_fail  = 0;
    int  op_cnt  = 0;
    int  maxd    = 4;
    bit  done_armed = 1'b0;
    bit  adv_r      = 1'b0;

    pyramid_sequencer #(
        .NUM_LEVELS(NL), .ITERS_PER_LEVEL(IT), .TIMEOUT_CYCLES(TO), .LVL_W(LW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .busy(busy), .done(done), .error(error), .op_start(op_start),
        .op_code(op_code), .op_level(op_level), .op_done(op_done),
        .iter_idx(iter_idx), .current_state(current_state)
    );

    always #5 clk = ~clk;

    function automatic op_t mk(input int c, input int l, input int i);
        op_t o;
        o.code = 3'(c);
        o.lvl  = 2'(l);
        o.iter = 2'(i);
        return o;
    endfunction

    // Reference op list built directly from the ordering rules
    task automatic push_sequence();
        exp_q.delete();
        exp_q.push_back(mk(0, 0, 0));
        exp_q.push_back(mk(1, 0, 0));
        for (int i = 1; i < IT; i++) begin
            exp_q.push_back(mk(3, 0, i));
            exp_q.push_back(mk(1, 0, i));
            exp_q.push_back(mk(4, 0, i));
        end
        for (int k = 1; k < NL; k++) begin
            exp_q.push_back(mk(2, k, 0));
            for (int i = 0; i < IT; i++) begin
                exp_q.push_back(mk(3, k, i));
                exp_q.push_back(mk(1, k, i));
                exp_q.push_back(mk(4, k, i));
            end
        end
    endtask

    task automatic check(input string name, input bit ok, input int got, input int req);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, got, req);
        end
    endtask

    // Any cycle where an op should launch or the sequence should finish
    always @(posedge clk) begin
        adv_r <= rst_n && ((op_done && current_state == 3'd2 && !abort) ||
                 (start && (current_state == 3'd0 || (current_state == 3'd4 && !abort))));
    end

    // Monitor: pops the scoreboard on every op_start and checks pulses/holds
    initial begin
        forever begin
            @(negedge clk);
            if (op_start) begin
                op_cnt++;
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL op_unexpected: got code=%0d lvl=%0d iter=%0d, required no op",
                             op_code, op_level, iter_idx);
                end else begin
                    exp_op  = exp_q.pop_front();
                    last_op = exp_op;
                    if ({op_code, op_level, iter_idx} !== exp_op || busy !== 1'b1) begin
                        n_fail++;
                        $display("FAIL op_issue: got code=%0d lvl=%0d iter=%0d busy=%0b, required code=%0d lvl=%0d iter=%0d busy=1",
                                 op_code, op_level, iter_idx, busy, exp_op.code, exp_op.lvl, exp_op.iter);
                    end
                end
            end
            if (current_state == 3'd2) begin
                n_tests++;
                if ({op_code, op_level, iter_idx} !== last_op || busy !== 1'b1 || op_start !== 1'b0) begin
                    n_fail++;
                    $display("FAIL wait_hold: got op=%0h busy=%0b op_start=%0b, required op=%0h busy=1 op_start=0",
                             {op_code, op_level, iter_idx}, busy, op_start, last_op);
                end
            end
            if (done) begin
                n_tests++;
                if (!done_armed || exp_q.size() != 0 || busy !== 1'b0) begin
                    n_fail++;
                    $display("FAIL done_pulse: got armed=%0b pending=%0d busy=%0b, required armed=1 pending=0 busy=0",
                             done_armed, exp_q.size(), busy);
                end
                done_armed = 1'b0;
            end
            if (adv_r) begin
                n_tests++;
                if (!(op_start || done)) begin
                    n_fail++;
                    $display("FAIL no_bubble: got op_start=%0b done=%0b, required one of them 1", op_start, done);
                end
            end
`ifndef PYR_SEQ_WATCHDOG_EN
            check("error_tied", error === 1'b0, int'(error), 0);
`endif
        end
    end

    // Answers each launched op after a random delay, optionally aborting one of them
    task automatic drive_ops(input int abort_at, input bit with_done, input bit poke, input int first_delay);
        int idx;
        int w;
        int d;
        bit fin;
        idx = 0;
        fin = 1'b0;
        while (!fin) begin
            w = 0;
            while (!op_start && !done && w < 64) begin
                @(negedge clk);
                w++;
            end
            if (done) begin
                @(negedge clk);
                check("done_one_cycle", done === 1'b0 && current_state === 3'd0, int'(current_state), 0);
                check("op_count", op_cnt == TOTAL, op_cnt, TOTAL);
                fin = 1'b1;
            end else if (!op_start) begin
                check("op_timeout", 1'b0, idx, TOTAL);
                fin = 1'b1;
            end else begin
                d = (idx == 0 && first_delay >= 0) ? first_delay : int'($urandom_range(maxd, 0));
                start = poke;
                @(negedge clk);
                start = 1'b0;
                repeat (d) @(negedge clk);
                if (idx == abort_at) begin
                    abort      = 1'b1;
                    op_done    = with_done;
                    exp_q.delete();
                    done_armed = 1'b0;
                    @(negedge clk);
                    abort   = 1'b0;
                    op_done = 1'b0;
                    check("abort_idle", current_state === 3'd0 && busy === 1'b0 && op_start === 1'b0,
                          int'(current_state), 0);
                    repeat (3) @(negedge clk);
                    fin = 1'b1;
                end else begin
                    op_done = 1'b1;
                    @(negedge clk);
                    op_done = 1'b0;
                end
                idx++;
            end
        end
    endtask

    task automatic run(input int abort_at, input bit with_done, input bit poke, input int first_delay);
        push_sequence();
        done_armed = 1'b1;
        op_cnt     = 0;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        drive_ops(abort_at, with_done, poke, first_delay);
    endtask

    task automatic check_all_zero(input string name);
        check(name, {busy, done, error, op_start, op_code, op_level, iter_idx, current_state} === '0,
              int'({busy, done, error, op_start, op_code, op_level, iter_idx, current_state}), 0);
    endtask

    initial begin
        start   = 1'b0;
        abort   = 1'b0;
        op_done = 1'b0;
        rst_n   = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset_state");
        rst_n = 1'b1;
        @(negedge clk);

        for (int r = 0; r < 3; r++) run(-1, 1'b0, 1'b0, -1);
        maxd = 0;
        run(-1, 1'b0, 1'b0, -1);
        maxd = 4;
        run(-1, 1'b0, 1'b1, -1);
        run(ABORT_IDX, 1'b0, 1'b0, -1);
        run(-1, 1'b0, 1'b0, -1);
        run(int'($urandom_range(TOTAL - 1, 0)), 1'b1, 1'b0, -1);

        op_done = 1'b1;
        @(negedge clk);
        op_done = 1'b0;
        @(negedge clk);
        check("op_done_idle", current_state === 3'd0 && op_start === 1'b0 && busy === 1'b0,
              int'(current_state), 0);

        for (int r = 0; r < 3; r++) begin
            run(int'($urandom_range(TOTAL - 1, 0)), 1'($urandom_range(1, 0)), 1'b0, -1);
            run(-1, 1'b0, 1'b0, -1);
        end

        // asynchronous reset in the middle of a sequence
        push_sequence();
        done_armed = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            op_done = 1'b1;
            @(negedge clk);
            op_done = 1'b0;
        end
        #2 rst_n = 1'b0;
        #1 check_all_zero("async_reset");
        exp_q.delete();
        done_armed = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run(-1, 1'b0, 1'b0, -1);

`ifdef PYR_SEQ_WATCHDOG_EN
        push_sequence();
        done_armed = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (TO) @(negedge clk);
        check("wd_before_trip", current_state === 3'd2 && error === 1'b0, int'(current_state), 2);
        @(negedge clk);
        check("wd_trip", current_state === 3'd4 && error === 1'b1 && busy === 1'b0, int'(current_state), 4);
        op_done = 1'b1;
        @(negedge clk);
        op_done = 1'b0;
        repeat (2) @(negedge clk);
        check("wd_hold", error === 1'b1 && op_start === 1'b0, int'(error), 1);
        push_sequence();
        done_armed = 1'b1;
        op_cnt = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("wd_restart", error === 1'b0 && op_start === 1'b1, int'(error), 0);
        drive_ops(-1, 1'b0, 1'b0, TO - 1);

        push_sequence();
        done_armed = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (TO + 1) @(negedge clk);
        check("wd_trip2", error === 1'b1, int'(error), 1);
        exp_q.delete();
        done_armed = 1'b0;
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        check("wd_abort_start", current_state === 3'd0 && error === 1'b0 && op_start === 1'b0,
              int'(current_state), 0);
        run(-1, 1'b0, 1'b0, -1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no summary, required completion");
        $fatal(1, "bench timed out");
    end

endmodule
